// File: rtl/matmul_pkg.sv
// Shared types and constants for the tiled MAC array controller.
// States, width helper and default sizing used by matmul_tile_ctrl and its loop counters.
package matmul_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int K_MAX_DEF    = 16;
   localparam int T_MAX_DEF    = 8;
   localparam int PIPE_LAT_DEF = 2;

   // Bits needed to hold every value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/matmul_loop_cnt.sv
// Loop index counter: synchronous clear, increment strobe, and a flag
// that marks the final iteration (value == limit-1).
module matmul_loop_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] value,
   output logic         last
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] r_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (clr) begin
         r_value <= '0;
      end else if (inc) begin
         r_value <= r_value + ONE;
      end
   end

   assign value = r_value;
   assign last  = (r_value == (limit - ONE));

endmodule

// File: rtl/matmul_tile_ctrl.sv
// Tile sequencer for the MAC array: per tile clears, accumulates k beats,
// drains the pipeline and hands the result to writeback. Optional MATMUL_PERF_CNT_EN adds stall_cnt.
module matmul_tile_ctrl
   import matmul_pkg::*;
#(
   parameter  int K_MAX    = K_MAX_DEF,
   parameter  int T_MAX    = T_MAX_DEF,
   parameter  int PIPE_LAT = PIPE_LAT_DEF,
   localparam int KW       = cnt_width(K_MAX),
   localparam int TW       = cnt_width(T_MAX)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic [TW-1:0] tile_cnt,
   input  logic          op_valid,
   output logic          op_ready,
   output logic          en,
   output logic          clear,
   output logic [KW-1:0] k,
   output logic [TW-1:0] tile,
   output logic          acc_last,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          busy,
   output logic          done,
   output logic          err
`ifdef MATMUL_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int DW = (PIPE_LAT > 0) ? cnt_width(PIPE_LAT) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);
   localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
   localparam logic [KW-1:0] K_LIM      = KW'(K_MAX);
   localparam logic [TW-1:0] T_LIM      = TW'(T_MAX);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [KW-1:0] r_k_len;
   logic [TW-1:0] r_tile_cnt;
   logic          r_err;
   logic [DW-1:0] r_drain_cnt;

   logic          w_start_acc;
   logic          w_illegal;
   logic          w_en;
   logic          w_res_hs;
   logic          w_k_last;
   logic          w_tile_last;

   // Handshakes: a beat transfers when op_valid & op_ready (RUN only); a
   // result transfers when res_valid & res_ready (WRITE only). Neither
   // ready nor valid ever depends on its partner in the same cycle.
   assign w_start_acc = (r_state == S_IDLE) & start;
   assign w_illegal   = (k_len == '0) | (k_len > K_LIM) |
                        (tile_cnt == '0) | (tile_cnt > T_LIM);
   assign w_en        = op_valid & (r_state == S_RUN);
   assign w_res_hs    = res_ready & (r_state == S_WRITE);

   matmul_loop_cnt #(.W(KW)) u_k_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (r_state == S_CLEAR),
      .inc   (w_en),
      .limit (r_k_len),
      .value (k),
      .last  (w_k_last)
   );

   matmul_loop_cnt #(.W(TW)) u_tile_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_start_acc),
      .inc   (w_res_hs & ~w_tile_last),
      .limit (r_tile_cnt),
      .value (tile),
      .last  (w_tile_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = w_illegal ? S_DONE : S_CLEAR;
         S_CLEAR: w_state_nxt = S_RUN;
         S_RUN:   if (w_en && w_k_last) w_state_nxt = (PIPE_LAT == 0) ? S_WRITE : S_DRAIN;
         S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_WRITE;
         S_WRITE: if (res_ready) w_state_nxt = w_tile_last ? S_DONE : S_CLEAR;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k_len     <= '0;
         r_tile_cnt  <= '0;
         r_err       <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         if (w_start_acc) begin
            r_k_len    <= k_len;
            r_tile_cnt <= tile_cnt;
            r_err      <= w_illegal;
         end
         r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + DRAIN_ONE) : '0;
      end
   end

   assign op_ready  = (r_state == S_RUN);
   assign en        = w_en;
   assign clear     = (r_state == S_CLEAR);
   assign acc_last  = w_en & w_k_last;
   assign res_valid = (r_state == S_WRITE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = (r_state == S_DONE) & r_err;

`ifdef MATMUL_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = ((r_state == S_RUN) & ~op_valid) | ((r_state == S_WRITE) & ~res_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_start_acc) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Directed bench for matmul_tile_ctrl (default K_MAX=16, T_MAX=8, PIPE_LAT=2).
// Cycle 0 is the cycle whose closing edge accepts start; outputs are sampled on negedge.
module tb_matmul_tile_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [4:0] k_len;
   logic [3:0] tile_cnt;
   logic       op_valid;
   logic       op_ready;
   logic       en;
   logic       clear;
   logic [4:0] k;
   logic [3:0] tile;
   logic       acc_last;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       done;
   logic       err;
`ifdef MATMUL_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   matmul_tile_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .tile_cnt  (tile_cnt),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .en        (en),
      .clear     (clear),
      .k         (k),
      .tile      (tile),
      .acc_last  (acc_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef MATMUL_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents a run request for one cycle (or leaves it high when hold=1),
   // then scrambles k_len/tile_cnt to show they are not used after capture.
   task automatic start_run(input logic [4:0] kl, input logic [3:0] tc, input bit hold);
      @(posedge clk);
      #1;
      start    = 1'b1;
      k_len    = kl;
      tile_cnt = tc;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      k_len    = 5'($urandom_range(0, 31));
      tile_cnt = 4'($urandom_range(0, 15));
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      start     = 1'b0;
      k_len     = '0;
      tile_cnt  = '0;
      op_valid  = 1'b1;
      res_ready = 1'b1;
      #23;
      checks++;
      if ({op_ready, en, clear, acc_last, res_valid, busy, done, err} !== 8'b0 ||
          k !== 5'd0 || tile !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: outs=%b k=%0d tile=%0d, required outs=0 k=0 tile=0",
                  {op_ready, en, clear, acc_last, res_valid, busy, done, err}, k, tile);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [5:0] exp_v;
      start_run(5'd4, 4'd1, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         op_valid  = 1'b1;
         res_ready = 1'b1;
         @(negedge clk);
         exp_v = {(c == 1), (c >= 2 && c <= 5), (c == 5), (c == 8), (c == 9), (c <= 9)};
         checks++;
         if ({clear, en, acc_last, res_valid, done, busy} !== exp_v) begin
            errors++;
            $display("FAIL basic_timing c=%0d: {clear,en,acc_last,res_valid,done,busy}=%b, required %b",
                     c, {clear, en, acc_last, res_valid, done, busy}, exp_v);
         end
         if (c >= 2 && c <= 5) begin
            checks++;
            if (k !== 5'(c - 2)) begin
               errors++;
               $display("FAIL basic_k c=%0d: k=%0d, required %0d", c, k, c - 2);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_multi_tile;
      int n_en = 0;
      int n_clr = 0;
      int n_done = 0;
      int done_cyc = -1;
      int en_per_tile[3] = '{0, 0, 0};
      int last_tile = 0;
      start_run(5'd3, 4'd3, 1'b0);
      for (int c = 1; c <= 36; c++) begin
         op_valid  = c[0];
         res_ready = 1'b1;
         @(negedge clk);
         if (en) begin
            n_en++;
            checks++;
            if (k >= 5'd3 || tile > 4'd2 || int'(tile) < last_tile) begin
               errors++;
               $display("FAIL multi_en_index c=%0d: k=%0d tile=%0d, required k<3 and tile in %0d..2",
                        c, k, tile, last_tile);
            end else begin
               en_per_tile[tile]++;
               last_tile = int'(tile);
            end
         end
         if (clear) n_clr++;
         if (done) begin
            n_done++;
            done_cyc = c;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (n_en !== 9 || n_clr !== 3 || n_done !== 1 || done_cyc !== 31) begin
         errors++;
         $display("FAIL multi_counts: en=%0d clear=%0d done=%0d done_cyc=%0d, required 9 3 1 31",
                  n_en, n_clr, n_done, done_cyc);
      end
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (en_per_tile[t] !== 3) begin
            errors++;
            $display("FAIL multi_tile_beats tile=%0d: en=%0d, required 3", t, en_per_tile[t]);
         end
      end
   endtask

   task automatic test_write_stall;
      logic [2:0] exp_v;
      start_run(5'd2, 4'd2, 1'b0);
      for (int c = 1; c <= 19; c++) begin
         op_valid  = 1'b1;
         res_ready = !(c >= 6 && c <= 10);
         @(negedge clk);
         exp_v = {(c == 1 || c == 12), ((c >= 6 && c <= 11) || c == 17), (c == 18)};
         checks++;
         if ({clear, res_valid, done} !== exp_v) begin
            errors++;
            $display("FAIL stall_timing c=%0d: {clear,res_valid,done}=%b, required %b",
                     c, {clear, res_valid, done}, exp_v);
         end
         if (c >= 6 && c <= 10) begin
            checks++;
            if (k !== 5'd2 || tile !== 4'd0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL stall_frozen c=%0d: k=%0d tile=%0d busy=%b, required 2 0 1",
                        c, k, tile, busy);
            end
         end
         if (c == 12) begin
            checks++;
            if (tile !== 4'd1) begin
               errors++;
               $display("FAIL stall_next_tile: tile=%0d, required 1", tile);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_illegal;
      logic [4:0] kl_tab[3] = '{5'd0, 5'd4, 5'd17};
      logic [3:0] tc_tab[3] = '{4'd1, 4'd9, 4'd1};
      for (int i = 0; i < 3; i++) begin
         start_run(kl_tab[i], tc_tab[i], 1'b0);
         op_valid  = 1'b1;
         res_ready = 1'b1;
         @(negedge clk);
         checks++;
         if ({done, err, clear, en, res_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL illegal_cfg%0d: {done,err,clear,en,res_valid}=%b, required 11000",
                     i, {done, err, clear, en, res_valid});
         end
         @(negedge clk);
         checks++;
         if ({done, err, busy, clear} !== 4'b0000) begin
            errors++;
            $display("FAIL illegal_after%0d: {done,err,busy,clear}=%b, required 0000",
                     i, {done, err, busy, clear});
         end
      end
   endtask

   task automatic test_reset_mid_run;
      bit         hit = 1'b0;
      logic [1:0] exp_v;
      start_run(5'd4, 4'd1, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         op_valid  = 1'b1;
         res_ready = 1'b1;
         @(negedge clk);
         if (en && k == 5'd2) begin
            hit = 1'b1;
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if ({op_ready, en, clear, acc_last, res_valid, busy, done, err} !== 8'b0 ||
                k !== 5'd0 || tile !== 4'd0) begin
               errors++;
               $display("FAIL async_reset: outs=%b k=%0d tile=%0d, required outs=0 k=0 tile=0",
                        {op_ready, en, clear, acc_last, res_valid, busy, done, err}, k, tile);
            end
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL async_reset_reach: k=2 beat seen=%b, required 1", hit);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: done=%b busy=%b, required 0 0", done, busy);
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      start_run(5'd2, 4'd1, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         op_valid  = 1'b1;
         res_ready = 1'b1;
         @(negedge clk);
         exp_v = {(c == 2 || c == 3), (c == 7)};
         checks++;
         if ({en, done} !== exp_v) begin
            errors++;
            $display("FAIL rerun_timing c=%0d: {en,done}=%b, required %b", c, {en, done}, exp_v);
         end
         if (c == 2 || c == 3) begin
            checks++;
            if (k !== 5'(c - 2)) begin
               errors++;
               $display("FAIL rerun_k c=%0d: k=%0d, required %0d", c, k, c - 2);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] exp_v;
      start_run(5'd1, 4'd1, 1'b1);
      for (int c = 1; c <= 14; c++) begin
         start     = (c <= 7);
         k_len     = 5'd1;
         tile_cnt  = 4'd1;
         op_valid  = 1'b1;
         res_ready = 1'b1;
         @(negedge clk);
         exp_v = {(c == 1 || c == 8), (c == 6 || c == 13), (c != 7 && c != 14)};
         checks++;
         if ({clear, done, busy} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back c=%0d: {clear,done,busy}=%b, required %b",
                     c, {clear, done, busy}, exp_v);
         end
         @(posedge clk);
         #1;
      end
   endtask

`ifdef MATMUL_PERF_CNT_EN
   task automatic test_perf_cnt;
      start_run(5'd2, 4'd1, 1'b0);
      for (int c = 1; c <= 14; c++) begin
         op_valid  = (c >= 6);
         res_ready = (c >= 12);
         @(negedge clk);
         if (c == 13) begin
            checks++;
            if (done !== 1'b1 || stall_cnt !== 32'd6) begin
               errors++;
               $display("FAIL perf_cnt: done=%b stall_cnt=%0d, required 1 6", done, stall_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_multi_tile();
      test_write_stall();
      test_illegal();
      test_reset_mid_run();
      test_back_to_back();
`ifdef MATMUL_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matmul_tile_ctrl.md
# matmul_tile_ctrl

- Control path for the tiled MAC array; successor to the single-tile K-loop controller.
- Sequences a run-time programmed number of output tiles. Each tile runs a run-time programmed number of k beats.
- Stalls on an operand valid/ready handshake and drains the MAC pipeline.
- Hands each finished tile to the writeback path through a valid/ready result handshake before starting the next tile.

## Interface
Parameters:
- K_MAX, 16: largest legal k_len. KW = $clog2(K_MAX+1).
- T_MAX, 8: largest legal tile_cnt. TW = $clog2(T_MAX+1).
- PIPE_LAT, 2: MAC pipeline depth in cycles, 0 allowed.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- k_len  in  KW  k beats per tile; captured when start is accepted.
- tile_cnt  in  TW  tiles per run; captured when start is accepted.
- op_valid  in  1  operand pair available this cycle.
- op_ready  out  1  high in RUN only.
- en  out  1  MAC accumulate strobe, equal to op_valid & op_ready.
- clear  out  1  accumulator clear, one cycle per tile.
- k  out  KW  index of the current beat.
- tile  out  TW  index of the current tile.
- acc_last  out  1  en on beat k_len-1.
- res_valid  out  1  tile result ready for writeback.
- res_ready  in  1  writeback accepts the result.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  one-cycle pulse, coincident with done, for an illegal configuration.

## Operation
States: IDLE, CLEAR, RUN, DRAIN, WRITE, DONE.
- IDLE, start=1:
  - Latch k_len and tile_cnt; tile <= 0.
  - If k_len==0, k_len>K_MAX, tile_cnt==0 or tile_cnt>T_MAX: go to DONE with err flagged.
  - Otherwise go to CLEAR.
- CLEAR: clear=1, k <= 0, go to RUN.
- RUN:
  - op_ready=1. On a handshake, k <= k+1.
  - On the handshake with k==k_len_q-1, go to DRAIN (or WRITE when PIPE_LAT==0).
  - With op_valid=0, hold the state, k and all indices.
- DRAIN: count PIPE_LAT cycles, then go to WRITE.
- WRITE:
  - res_valid=1, held until res_ready.
  - On the handshake: if tile==tile_cnt_q-1, go to DONE; else tile <= tile+1 and go to CLEAR.
- DONE: done=1 (err=1 if flagged), go to IDLE unconditionally; start need not fall.
- start is ignored outside IDLE. k_len and tile_cnt may change freely after capture.
- k never exceeds k_len_q-1 at a handshake and is never observed beyond k_len_q. tile never wraps.

## Timing
- Reset values: state IDLE; k=0, tile=0; all 1-bit outputs 0.
- Reset assertion mid-run returns to IDLE immediately (asynchronous). No done is produced.
- Outputs are decoded from registered state and indices. en and op_ready have no input-to-output path other than op_valid.
- res_valid does not depend on res_ready.
- Zero-stall latency, start accepted at cycle 0:
  - Per tile: CLEAR at cycle 1; RUN over cycles 2..k_len+1; DRAIN PIPE_LAT cycles; WRITE 1 cycle.
  - done on cycle 1 + tile_cnt·(k_len+PIPE_LAT+2).
- Each op_valid=0 cycle in RUN and each res_ready=0 cycle in WRITE adds exactly one cycle.
- Illegal configuration: done=err=1 on cycle 1.
- start held high through DONE launches the next run on the cycle after DONE (IDLE sees start).

## Configuration
- MATMUL_PERF_CNT_EN defined:
  - Adds output stall_cnt [31:0].
  - Counts RUN cycles with op_valid=0 plus WRITE cycles with res_ready=0.
  - Cleared on reset and on start acceptance; saturates at all-ones.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- matmul_pkg:
  - state_t enum, 3 bits.
  - Width helper function for KW and TW.
  - Default parameter constants.
- Sub-module matmul_loop_cnt, parametrised width, instantiated twice (k and tile):
  - Inputs: clr, inc, limit.
  - Outputs: value, last = (value==limit-1).

## Test plan
- k_len=4, tile_cnt=1, PIPE_LAT=2, op_valid=1, res_ready=1 -> clear at cycle 1; en over cycles 2-5 with k 0..3; acc_last at cycle 5; res_valid at cycle 8; done at cycle 9.
- k_len=3, tile_cnt=3, op_valid toggling 1,0 -> exactly 9 en pulses; tile steps 0,1,2; three clear pulses; done once; no k value ≥3 at en.
- res_ready held 0 for 5 cycles in WRITE -> res_valid stays 1 and state frozen for those 5 cycles; the next tile's clear follows the handshake by one cycle.
- k_len=0, and separately tile_cnt=T_MAX+1 -> done=err=1 one cycle after start; no clear, en or res_valid.
- rst_n pulsed low in RUN at k=2 -> all outputs 0 asynchronously; busy=0; a subsequent start runs normally from k=0.
- MATMUL_PERF_CNT_EN defined with 4 op_valid-low cycles and 2 res_ready-low cycles -> stall_cnt=6 at done.
